// File: rtl/seg_mux_driver.sv
// seg_mux_driver: multiplexed 7-segment display driver.
// Scans NUM_DIGITS packed BCD digits onto a shared segment bus with a one-hot
// digit enable, per-slot PWM brightness, optional leading-zero blanking and a
// double-buffered digit load that only swaps at frame start.
module seg_mux_driver #(
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned REFRESH_DIV = 256,
    parameter int unsigned PWM_BITS    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    load,
    input  logic [PWM_BITS-1:0]     brightness,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // Timebase and scan state
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [PWM_BITS-1:0]     pwm_q, pwm_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PWM_BITS-1:0]     bright_q, bright_d;
    logic                    wrap_q, wrap_d;

    // Digit buffers
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] act_q, act_d;

    // Registered outputs
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    done_q, done_d;

    // Decode helpers
    logic                    tick;
    logic                    pwm_wrap;
    logic                    slot_start;
    logic                    frame_start;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    all_zero;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h67;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Prescaler, PWM counter, digit index and buffer next-state
    always_comb begin
        tick        = (presc_q == PRE_MAX);
        pwm_wrap    = tick && (pwm_q == '1);
        slot_start  = (presc_q == '0) && (pwm_q == '0);
        frame_start = slot_start && (idx_q == '0);

        presc_d = tick ? '0 : presc_q + 1'b1;
        pwm_d   = tick ? pwm_q + 1'b1 : pwm_q;
        idx_d   = idx_q;
        if (pwm_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        wrap_d = pwm_wrap && (idx_q == IDX_MAX);

        // Slot-start values are used in the same cycle they are sampled,
        // so the first cycle of a slot already reflects the new brightness
        // and the first cycle of a frame already shows the new digits.
        bright_d = slot_start ? brightness : bright_q;
        act_d    = frame_start ? pend_q : act_q;
        pend_d   = load ? digits : pend_q;
    end

    // Leading-zero mask: digit i blanks when it and every higher digit is zero
    always_comb begin
        all_zero = 1'b1;
        lz_blank = '0;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            all_zero = all_zero && (act_d[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            lz_blank[NUM_DIGITS-1-k] = all_zero && blank_lz;
        end
    end

    // Output next-state: gated segment pattern, one-hot enable, frame pulse
    always_comb begin
        cur_digit = act_d[{idx_q, 2'b00} +: 4];
        seg_d     = '0;
        if ((pwm_q < bright_d) && !lz_blank[idx_q]) begin
            seg_d = bcd_to_seg(cur_digit);
        end
        en_d        = '0;
        en_d[idx_q] = 1'b1;
        done_d      = wrap_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            pwm_q    <= '0;
            idx_q    <= '0;
            bright_q <= '0;
            wrap_q   <= 1'b0;
            pend_q   <= '0;
            act_q    <= '0;
            seg_q    <= '0;
            en_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            pwm_q    <= pwm_d;
            idx_q    <= idx_d;
            bright_q <= bright_d;
            wrap_q   <= wrap_d;
            pend_q   <= pend_d;
            act_q    <= act_d;
            seg_q    <= seg_d;
            en_q     <= en_d;
            done_q   <= done_d;
        end
    end

    assign seg        = seg_q;
    assign digit_en   = en_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed bench for seg_mux_driver with a 16-clk slot and 64-clk frame.
// Cycle n (cyc) is the n-th clock after reset release; the outputs seen in
// cycle n describe internal scan position n-1.
module tb_seg_mux_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic        load;
    logic [1:0]  brightness;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  digit_en;
    logic        frame_done;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned on_cnt;

    seg_mux_driver #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .PWM_BITS   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digits    (digits),
        .load      (load),
        .brightness(brightness),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int unsigned t);
        while (cyc < t) step();
    endtask

    task automatic chk_out(input string tag, input logic [6:0] s, input logic [3:0] en);
        check({tag, ".seg"}, {25'd0, seg}, {25'd0, s});
        check({tag, ".en"}, {28'd0, digit_en}, {28'd0, en});
    endtask

    task automatic do_load(input logic [15:0] v);
        digits = v;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic count_on(input string tag, input int unsigned start, input int unsigned exp);
        go_to(start);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (seg != 7'h00) on_cnt++;
            step();
        end
        check(tag, on_cnt, exp);
    endtask

    initial begin
        reset      = 1'b1;
        digits     = 16'h0000;
        load       = 1'b0;
        brightness = 2'd3;
        blank_lz   = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        cyc = 0;

        // Reset state
        chk_out("rst", 7'h00, 4'b0000);
        check("rst.fd", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;

        // First cycle after release: digit 0, zeros shown as "0"
        go_to(1);
        chk_out("rel", 7'h3F, 4'b0001);
        check("rel.fd", {31'd0, frame_done}, 32'd0);

        // Load 1234 mid frame 0; frame 0 keeps showing zeros
        go_to(10);
        do_load(16'h1234);
        go_to(17);
        chk_out("f0.d1", 7'h3F, 4'b0010);

        // Frame 1 shows 1234, 12 on / 4 off per slot
        go_to(64);
        check("fd.pre", {31'd0, frame_done}, 32'd0);
        go_to(65);
        chk_out("f1.d0.on", 7'h66, 4'b0001);
        check("fd.f1", {31'd0, frame_done}, 32'd1);
        go_to(66);
        check("fd.post", {31'd0, frame_done}, 32'd0);
        go_to(77);
        chk_out("f1.d0.off", 7'h00, 4'b0001);
        count_on("f1.d1.ontime", 81, 12);
        go_to(97);
        chk_out("f1.d2.on", 7'h5B, 4'b0100);
        go_to(109);
        chk_out("f1.d2.off", 7'h00, 4'b0100);
        go_to(113);
        chk_out("f1.d3.on", 7'h06, 4'b1000);
        go_to(125);
        chk_out("f1.d3.off", 7'h00, 4'b1000);
        go_to(128);
        check("fd.f2pre", {31'd0, frame_done}, 32'd0);
        go_to(129);
        check("fd.f2", {31'd0, frame_done}, 32'd1);

        // Brightness 1 from the next slot; current slot keeps 3
        brightness = 2'd1;
        go_to(137);
        chk_out("f2.d0.mid", 7'h66, 4'b0001);
        count_on("f2.d1.ontime", 145, 4);
        brightness = 2'd0;
        go_to(177);
        chk_out("f2.d3.dark", 7'h00, 4'b1000);
        go_to(193);
        chk_out("f3.d0.dark", 7'h00, 4'b0001);
        check("fd.f3", {31'd0, frame_done}, 32'd1);

        // Leading-zero blanking with 0050
        go_to(200);
        brightness = 2'd3;
        blank_lz   = 1'b1;
        do_load(16'h0050);
        go_to(257);
        chk_out("lz.d0", 7'h3F, 4'b0001);
        go_to(273);
        chk_out("lz.d1", 7'h6D, 4'b0010);
        go_to(289);
        chk_out("lz.d2", 7'h00, 4'b0100);
        go_to(305);
        chk_out("lz.d3", 7'h00, 4'b1000);
        go_to(306);
        do_load(16'h0000);
        go_to(321);
        chk_out("lz0.d0", 7'h3F, 4'b0001);
        go_to(337);
        chk_out("lz0.d1", 7'h00, 4'b0010);
        go_to(369);
        chk_out("lz0.d3", 7'h00, 4'b1000);
        go_to(370);
        blank_lz = 1'b0;
        go_to(401);
        chk_out("nolz.d1", 7'h3F, 4'b0010);

        // Tear-free load during digit 2's slot
        go_to(420);
        do_load(16'h9999);
        go_to(433);
        chk_out("tear.old.d3", 7'h3F, 4'b1000);
        go_to(449);
        chk_out("tear.new.d0", 7'h67, 4'b0001);
        go_to(465);
        chk_out("tear.new.d1", 7'h67, 4'b0010);
        go_to(481);
        chk_out("tear.new.d2", 7'h67, 4'b0100);
        go_to(497);
        chk_out("tear.new.d3", 7'h67, 4'b1000);

        // Load on the frame-start cycle waits one frame
        go_to(512);
        do_load(16'h5678);
        go_to(513);
        chk_out("fs.hold.d0", 7'h67, 4'b0001);
        go_to(561);
        chk_out("fs.hold.d3", 7'h67, 4'b1000);
        go_to(577);
        chk_out("fs.new.d0", 7'h7F, 4'b0001);
        go_to(625);
        chk_out("fs.new.d3", 7'h6D, 4'b1000);

        // Invalid codes decode blank
        go_to(630);
        blank_lz = 1'b1;
        do_load(16'hFA00);
        go_to(641);
        chk_out("inv.d0", 7'h3F, 4'b0001);
        go_to(657);
        chk_out("inv.d1", 7'h3F, 4'b0010);
        go_to(673);
        chk_out("inv.d2", 7'h00, 4'b0100);

        // Reset during digit 2's slot
        go_to(676);
        reset = 1'b1;
        step();
        chk_out("mrst", 7'h00, 4'b0000);
        check("mrst.fd", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        go_to(678);
        chk_out("mrst.rel.d0", 7'h3F, 4'b0001);
        go_to(689);
        chk_out("mrst.pwm2", 7'h3F, 4'b0001);
        go_to(690);
        chk_out("mrst.pwm3", 7'h00, 4'b0001);
        go_to(694);
        chk_out("mrst.d1", 7'h00, 4'b0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/seg_mux_driver.md
Name: seg_mux_driver

Overview:
Parametrised multiplexed 7-segment display driver. It takes NUM_DIGITS packed BCD digits and scans them one at a time onto a shared segment bus with a one-hot digit enable. Brightness is set by an internal PWM per digit slot, so the external duty-cycle gating the single-digit driver needed is no longer required. Optional leading-zero blanking and a double-buffered digit load prevent tearing; it sits between the clock's time/date formatter and the display pins.

Parameters:
NUM_DIGITS, 6, number of multiplexed digits (2..16); digit 0 is least significant
REFRESH_DIV, 256, clk cycles per PWM tick (>=2)
PWM_BITS, 4, brightness resolution; a digit slot lasts 2^PWM_BITS ticks

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
digits  in  4*NUM_DIGITS  packed BCD; digit i = digits[4i+3:4i]
load  in  1  single-cycle strobe; captures digits into the pending buffer
brightness  in  PWM_BITS  on-ticks per slot (0 = dark)
blank_lz  in  1  1 = blank leading zeros
seg  out  7  segments, active-high; bit0=a..bit6=g
digit_en  out  NUM_DIGITS  one-hot active-high digit select
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high. While reset is high at a clk edge, all of the following are zero: seg, digit_en, frame_done, prescaler, PWM counter, digit index, pending buffer and active buffer.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick is asserted when the count equals REFRESH_DIV-1.
- PWM counter (PWM_BITS wide):
  - Increments on tick and wraps at 2^PWM_BITS-1.
  - On a wrap, the digit index advances: 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0.
- Timing: slot = REFRESH_DIV*2^PWM_BITS clks; frame = NUM_DIGITS slots.
- Brightness sampling: brightness is sampled into slot_bright at slot start (PWM count 0, on the first cycle of the slot). Changes mid-slot take effect at the next slot.
- Segment gating: seg shows the digit's pattern when pwm_cnt < slot_bright, otherwise 0. Maximum on-time is (2^PWM_BITS-1)/2^PWM_BITS.
- Digit enable: digit_en = one-hot(index) for the whole slot, independent of the PWM gate. It is never multi-hot and is never asserted during reset.
- Decode (seg hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=67. Codes 10..15 decode to 00 (blank).
- Leading-zero blanking: with blank_lz=1, digit i is blanked when it and all digits above it are 0. Digit 0 is never blanked by this rule. blank_lz is evaluated against the active buffer.
- Double buffer:
  - load copies digits into the pending buffer on the same edge.
  - Pending is copied to active on the first cycle of digit-0's slot (frame start).
  - A load on that exact cycle is captured into pending but is not transferred until the next frame.
  - The displayed value never changes mid-frame.
- Outputs: seg, digit_en and frame_done are registered, one clk after the internal state.
- frame_done: pulses high for one cycle when the index wraps NUM_DIGITS-1 -> 0.
- Reset mid-frame: reset aborts the scan. After release, the scan restarts at digit 0 with PWM count 0, and the active buffer holds all zeros, displayed as "0" in digit 0 (with blank_lz=1 the higher digits are blank).
- Brightness 0: seg stays 0 while digit_en continues to scan.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, PWM_BITS=2 -> slot 16 clks, frame 64 clks):
- Reset: hold reset 3 clks -> seg=00, digit_en=0000, frame_done=0. The first clk after release gives digit_en=0001 one cycle later.
- Load and display: load digits=16'h1234, brightness=3 -> from the next frame, slots show seg 66,4F,5B,06 with digit_en 0001,0010,0100,1000. Each slot has seg on for 12 clks and 0 for 4 clks. frame_done pulses every 64 clks.
- Brightness: brightness=1 -> seg on for 4 of 16 clks per slot. brightness=0 -> seg always 00 while digit_en still rotates.
- Leading-zero blanking: digits=16'h0050, blank_lz=1 -> digits 3 and 2 show 00, digit 1 shows 6D, digit 0 shows 3F. With digits=16'h0000, only digit 0 shows 3F. With blank_lz=0, all digits show 3F.
- Tear-free load: load 16'h9999 in mid-frame, during digit 2's slot -> the remaining slots of that frame show the old value, and the next frame shows 67 on all digits. A load on the frame-start cycle is delayed by one frame.
- Invalid codes and reset mid-operation: digits=16'hFA00 -> digits 3 and 2 blank. Asserting reset during digit 2's slot -> outputs are zero the next cycle, and after release the scan resumes at digit 0 showing 3F (the active buffer has been cleared).
